// File: rtl/i2c_pkg.sv
// i2c_pkg: shared widths, opcodes, FSM encodings and index-width helper for I2C-mapped register banks
package i2c_pkg;
    localparam int I2C_ADDR_W = 11;
    localparam int I2C_DATA_W = 8;
    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/i2c_addr_decode.sv
// i2c_addr_decode: classifies an I2C byte address against a register bank
// addr -> in_range (addr < NUM_REGS on all bits), ro (status window),
// reg_idx (control register index), sts_idx (status byte index)
module i2c_addr_decode
    import i2c_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int RO_BASE  = 12,
    localparam int CW = idx_w(RO_BASE),
    localparam int SW = idx_w(NUM_REGS - RO_BASE)
) (
    input  logic [I2C_ADDR_W-1:0] addr,
    output logic                  in_range,
    output logic                  ro,
    output logic [CW-1:0]         reg_idx,
    output logic [SW-1:0]         sts_idx
);
    // Extra top bit keeps the compare exact even when NUM_REGS equals 2**I2C_ADDR_W
    assign in_range = {1'b0, addr} < (I2C_ADDR_W + 1)'(NUM_REGS);
    assign ro       = in_range && (addr >= I2C_ADDR_W'(RO_BASE));
    assign reg_idx  = addr[CW-1:0];
    assign sts_idx  = SW'(addr - I2C_ADDR_W'(RO_BASE));
endmodule

// File: rtl/i2c_reg_responder.sv
// i2c_reg_responder: register bank behind the I2C slave sequencer transfer bus
// Clock/reset: posedge clock, synchronous active-high reset
// i2c_xfc/op/addr_in/data_in: single-cycle transfer request
// i2c_data_out/valid/busy/err: read response, busy and illegal-access pulse
// overrun: sticky, request seen while busy
// status_in: read-only status bytes; ctrl_out: read/write control bytes
// wr_strobe/wr_index: committed-write pulse and address of last committed write
module i2c_reg_responder
    import i2c_pkg::*;
#(
    parameter int                    NUM_REGS = 16,
    parameter int                    RO_BASE  = 12,
    parameter logic [I2C_DATA_W-1:0] RD_FILL  = 8'hFF
) (
    input  logic                                      Clock,
    input  logic                                      reset,
    input  logic                                      i2c_xfc,
    input  logic                                      i2c_op,
    input  logic [I2C_ADDR_W-1:0]                     i2c_addr_in,
    input  logic [I2C_DATA_W-1:0]                     i2c_data_in,
    output logic [I2C_DATA_W-1:0]                     i2c_data_out,
    output logic                                      i2c_data_valid,
    output logic                                      i2c_busy,
    output logic                                      i2c_err,
    output logic                                      overrun,
    input  logic [I2C_DATA_W*(NUM_REGS-RO_BASE)-1:0]  status_in,
    output logic [I2C_DATA_W*RO_BASE-1:0]             ctrl_out,
    output logic                                      wr_strobe,
    output logic [I2C_ADDR_W-1:0]                     wr_index
);
    localparam int NS = NUM_REGS - RO_BASE;
    localparam int CW = idx_w(RO_BASE);
    localparam int SW = idx_w(NS);

    logic [1:0]                              state_q, state_d;
    logic                                    op_q, op_d;
    logic [I2C_ADDR_W-1:0]                   addr_q, addr_d;
    logic [I2C_DATA_W-1:0]                   wdata_q, wdata_d;
    logic [RO_BASE-1:0][I2C_DATA_W-1:0]      ctrl_q, ctrl_d;
    logic [I2C_DATA_W-1:0]                   dout_q, dout_d;
    logic                                    valid_q, valid_d;
    logic                                    err_q, err_d;
    logic                                    wstb_q, wstb_d;
    logic [I2C_ADDR_W-1:0]                   widx_q, widx_d;
    logic                                    ovr_q, ovr_d;
    logic [NS-1:0][I2C_DATA_W-1:0]           sts;
    logic                                    in_range, ro;
    logic [CW-1:0]                           reg_idx;
    logic [SW-1:0]                           sts_idx;
    logic [I2C_DATA_W-1:0]                   rd_data;

    i2c_addr_decode #(.NUM_REGS(NUM_REGS), .RO_BASE(RO_BASE)) u_dec (
        .addr     (addr_q),
        .in_range (in_range),
        .ro       (ro),
        .reg_idx  (reg_idx),
        .sts_idx  (sts_idx)
    );

    assign sts     = status_in;
    assign rd_data = !in_range ? RD_FILL : ro ? sts[sts_idx] : ctrl_q[reg_idx];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ctrl_d  = ctrl_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        wstb_d  = 1'b0;
        widx_d  = widx_q;
        // Any request outside IDLE, including the RESP->IDLE cycle, is dropped
        ovr_d   = ovr_q | (i2c_xfc && state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (i2c_xfc) begin
                    op_d    = i2c_op;
                    addr_d  = i2c_addr_in;
                    wdata_d = i2c_data_in;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_RESP;
                if (op_q == OP_WRITE) begin
                    if (in_range && !ro) begin
                        ctrl_d[reg_idx] = wdata_q;
                        wstb_d          = 1'b1;
                        widx_d          = addr_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    dout_d  = rd_data;
                    valid_d = 1'b1;
                    err_d   = !in_range;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            ctrl_q  <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            wstb_q  <= 1'b0;
            widx_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ctrl_q  <= ctrl_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            wstb_q  <= wstb_d;
            widx_q  <= widx_d;
            ovr_q   <= ovr_d;
        end
    end

    assign i2c_busy       = state_q != ST_IDLE;
    assign i2c_data_out   = dout_q;
    assign i2c_data_valid = valid_q;
    assign i2c_err        = err_q;
    assign wr_strobe      = wstb_q;
    assign wr_index       = widx_q;
    assign overrun        = ovr_q;
    assign ctrl_out       = ctrl_q;
endmodule

// File: tb/tb_i2c_reg_responder.sv
// tb_i2c_reg_responder: scoreboard bench for i2c_reg_responder
module tb_i2c_reg_responder;
    logic        Clock = 1'b0;
    logic        reset = 1'b1;
    logic        i2c_xfc = 1'b0;
    logic        i2c_op = 1'b0;
    logic [10:0] i2c_addr_in = '0;
    logic [7:0]  i2c_data_in = '0;
    logic [7:0]  i2c_data_out;
    logic        i2c_data_valid, i2c_busy, i2c_err, overrun, wr_strobe;
    logic [31:0] status_in;
    logic [95:0] ctrl_out;
    logic [10:0] wr_index;

    typedef struct {
        int          cyc;
        bit          rd;
        bit          er;
        bit          ws;
        logic [7:0]  d;
        logic [10:0] ix;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] ctrl_m[12];
    logic [7:0] sts_m[4];
    logic [7:0] last_rd;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;

    i2c_reg_responder dut (
        .Clock          (Clock),
        .reset          (reset),
        .i2c_xfc        (i2c_xfc),
        .i2c_op         (i2c_op),
        .i2c_addr_in    (i2c_addr_in),
        .i2c_data_in    (i2c_data_in),
        .i2c_data_out   (i2c_data_out),
        .i2c_data_valid (i2c_data_valid),
        .i2c_busy       (i2c_busy),
        .i2c_err        (i2c_err),
        .overrun        (overrun),
        .status_in      (status_in),
        .ctrl_out       (ctrl_out),
        .wr_strobe      (wr_strobe),
        .wr_index       (wr_index)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc++;
    assign status_in = {sts_m[3], sts_m[2], sts_m[1], sts_m[0]};

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [95:0] ctrl_flat();
        logic [95:0] v;
        for (int k = 0; k < 12; k++) v[8*k +: 8] = ctrl_m[k];
        return v;
    endfunction

    always @(negedge Clock) begin
        exp_t e;
        if (!reset && (i2c_data_valid || i2c_err || wr_strobe)) begin
            if (sb.size() == 0) begin
                chk("spurious", {i2c_data_valid, i2c_err, wr_strobe}, 0);
            end else begin
                e = sb.pop_front();
                chk("resp_cycle", cyc, e.cyc);
                chk("valid", i2c_data_valid, e.rd);
                chk("err", i2c_err, e.er);
                chk("wr_strobe", wr_strobe, e.ws);
                if (e.rd) chk("rdata", i2c_data_out, e.d);
                if (e.ws) chk("wr_index", wr_index, e.ix);
            end
        end
    end

    task automatic clear_model();
        for (int k = 0; k < 12; k++) ctrl_m[k] = 8'h00;
        last_rd = 8'h00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge Clock);
        reset = 1'b0;
        clear_model();
    endtask

    // Drives one request at the current negedge and returns at the negedge of N+3.
    // dup=1/2 fires a stray write request in cycle N+1/N+2 that must be dropped.
    task automatic xfer(input bit op, input int addr, input logic [7:0] d, input int dup = 0);
        exp_t e;
        bit   in_r, ro;
        in_r  = addr < 16;
        ro    = in_r && addr >= 12;
        e.cyc = cyc + 2;
        e.rd  = !op;
        e.ws  = op && in_r && !ro;
        e.er  = op ? !e.ws : !in_r;
        e.ix  = addr[10:0];
        e.d   = 8'hFF;
        if (ro) e.d = sts_m[addr-12];
        else if (in_r) e.d = ctrl_m[addr];
        if (e.ws) ctrl_m[addr] = d;
        if (e.rd) last_rd = e.d;
        sb.push_back(e);
        i2c_xfc     = 1'b1;
        i2c_op      = op;
        i2c_addr_in = addr[10:0];
        i2c_data_in = d;
        @(negedge Clock);
        i2c_xfc     = (dup == 1);
        i2c_op      = 1'b1;
        i2c_addr_in = 11'd5;
        i2c_data_in = 8'hEE;
        chk("busy_n1", i2c_busy, 1);
        @(negedge Clock);
        i2c_xfc = (dup == 2);
        chk("busy_n2", i2c_busy, 1);
        @(negedge Clock);
        i2c_xfc = 1'b0;
        chk("busy_n3", i2c_busy, 0);
        chk("ctrl_out", ctrl_out, ctrl_flat());
        chk("data_hold", i2c_data_out, last_rd);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) sts_m[k] = 8'h00;
        clear_model();
        repeat (2) @(negedge Clock);
        reset = 1'b0;
        chk("rst_busy", i2c_busy, 0);
        chk("rst_outs", {i2c_data_valid, i2c_err, wr_strobe, overrun}, 0);
        chk("rst_dout", i2c_data_out, 0);
        chk("rst_widx", wr_index, 0);
        chk("rst_ctrl", ctrl_out, 0);

        xfer(1, 3, 8'h5A);
        xfer(1, 3, 8'h77);
        xfer(0, 3, 8'h00);
        sts_m[1] = 8'hC3;
        xfer(0, 13, 8'h00);
        xfer(1, 13, 8'h11);
        xfer(0, 13, 8'h00);
        xfer(0, 'h400, 8'h00);
        xfer(1, 'h010, 8'hAB);
        xfer(1, 11, 8'h3C);
        xfer(0, 15, 8'h00);
        xfer(0, 'h7FF, 8'h00);
        chk("ovr_clear", overrun, 0);
        xfer(1, 7, 8'h21, 1);
        chk("ovr_set", overrun, 1);
        xfer(0, 7, 8'h00);
        chk("ovr_held", overrun, 1);

        do_reset();
        chk("rst2_ovr", overrun, 0);
        chk("rst2_ctrl", ctrl_out, 0);
        chk("rst2_dout", i2c_data_out, 0);
        xfer(0, 1, 8'h00, 2);
        chk("ovr_resp_edge", overrun, 1);

        do_reset();
        i2c_xfc     = 1'b1;
        i2c_op      = 1'b1;
        i2c_addr_in = 11'd2;
        i2c_data_in = 8'h99;
        @(negedge Clock);
        i2c_xfc = 1'b0;
        reset   = 1'b1;
        @(negedge Clock);
        reset = 1'b0;
        chk("abort_busy", i2c_busy, 0);
        chk("abort_ctrl", ctrl_out, 0);
        chk("abort_wstb", wr_strobe, 0);
        @(negedge Clock);
        chk("abort_busy2", i2c_busy, 0);
        chk("abort_pulses", {i2c_data_valid, i2c_err, wr_strobe}, 0);
        xfer(0, 2, 8'h00);

        for (int i = 0; i < 40; i++) begin
            int a;
            a = $urandom_range(0, 19);
            if (a == 19) a = $urandom_range(16, 2047);
            if ($urandom_range(0, 3) == 0) sts_m[$urandom_range(0, 3)] = 8'($urandom);
            xfer(1'($urandom), a, 8'($urandom));
        end

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/i2c_reg_responder.md
Name: i2c_reg_responder

Overview:
Register-bank responder on the far end of the I2C slave sequencer's transfer bus. It accepts each single-cycle i2c_xfc strobe with op/address/data, then:
- commits writes into a bank of read/write control registers, or
- services reads from the control registers or live read-only status inputs.
It returns read data with a valid pulse, flags illegal accesses, and exposes the control registers to the rest of the chip.

Parameters:
NUM_REGS, 16, total mapped byte registers at addresses 0..NUM_REGS-1.
RO_BASE, 12, first read-only address; addresses RO_BASE..NUM_REGS-1 map to status_in bytes. Must satisfy 1 <= RO_BASE <= NUM_REGS.
RD_FILL, 8'hFF, data returned for out-of-range reads.

Ports:
Clock  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
i2c_xfc  input  1  single-cycle transfer strobe from the sequencer
i2c_op  input  1  1 = write, 0 = read; sampled with i2c_xfc
i2c_addr_in  input  11  byte address; sampled with i2c_xfc
i2c_data_in  input  8  write data; sampled with i2c_xfc
i2c_data_out  output  8  read data
i2c_data_valid  output  1  one-cycle pulse when i2c_data_out holds a fresh read result
i2c_busy  output  1  high while a transfer is in progress
i2c_err  output  1  one-cycle pulse on an illegal access
overrun  output  1  sticky; set when i2c_xfc arrives while busy
status_in  input  8*(NUM_REGS-RO_BASE)  read-only status bytes, byte k at address RO_BASE+k
ctrl_out  output  8*RO_BASE  flattened read/write registers, byte k at address k
wr_strobe  output  1  one-cycle pulse when a control register is updated
wr_index  output  11  address of the last committed write

Behaviour:
- Reset, checked before everything else: all outputs and control registers go to 0, FSM to IDLE, sticky overrun cleared. Reset mid-transfer aborts it: no write commit, no valid pulse, no error pulse.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE: i2c_busy=0. On i2c_xfc=1, latch op, address and data, then go to EXEC.
- EXEC: i2c_busy=1. Classify the address:
  - in_range: addr < NUM_REGS, compared on the full 11 bits with no truncation.
  - ro: in_range and addr >= RO_BASE.
- EXEC, write:
  - in_range and not ro: update the register at this edge, pulse wr_strobe for the following cycle, set wr_index=addr.
  - otherwise: no state change, raise the error flag.
- EXEC, read:
  - Control address: register value.
  - Status address: status_in sampled in this cycle.
  - Out-of-range address: RD_FILL, and raise the error flag.
  - The result loads i2c_data_out at the EXEC->RESP edge.
- RESP: i2c_busy=1.
  - i2c_data_valid=1 for reads only.
  - i2c_err=1 if flagged.
  - wr_strobe=1 for a committed write.
  - Then go to IDLE.
- Latency: xfc in cycle N -> i2c_data_valid / i2c_err / wr_strobe in cycle N+2. A write is visible on ctrl_out from cycle N+2. The next xfc is accepted in cycle N+3.
- i2c_data_out holds its value until the next read completes; it is not cleared after the valid pulse.
- i2c_xfc in EXEC or RESP: ignored and sets overrun, which stays set until reset. The in-flight transfer completes unaffected.
- i2c_xfc in the same cycle as RESP->IDLE: counts as busy, so it is ignored and sets overrun.
- Status inputs are treated as synchronous to Clock; no synchronizers inside this block.

Decomposition:
- Shared package i2c_pkg holds:
  - I2C_ADDR_W=11 and I2C_DATA_W=8;
  - OP_READ=0 and OP_WRITE=1;
  - FSM state encodings ST_IDLE, ST_EXEC, ST_RESP.
- One natural sub-module: i2c_addr_decode. It is combinational and maps address -> in_range, ro, reg index, status index, so the decode can be reused by other I2C-mapped banks.
- Register storage and FSM stay in the top.

Test Plan:
- Write 0x5A to address 3 (xfc cycle N) -> wr_strobe at N+2, wr_index=3, ctrl_out byte 3=0x5A; other bytes stay 0; i2c_err=0.
- Write 0x77 to address 3, then read address 3 -> i2c_data_valid at N+2 with i2c_data_out=0x77, i2c_busy high in N+1..N+2.
- status_in byte 1=0xC3, read address 13 -> data 0xC3. Write 0x11 to address 13 -> i2c_err pulse, no wr_strobe, read-back still 0xC3.
- Read address 0x400 -> i2c_data_out=0xFF with i2c_data_valid and i2c_err both pulsed at N+2. Write to 0x010 -> i2c_err, no register change.
- xfc at N then xfc again at N+1 -> second ignored, overrun=1 and held. The first transfer still completes at N+2; reset clears overrun and all registers.
- Assert reset in the EXEC cycle of a write to address 2 -> ctrl_out byte 2 stays 0, no wr_strobe, FSM IDLE, i2c_busy=0 the cycle after reset.
